// File: rtl/fifo_pack_pkg.sv
// Shared types and sizing helpers for the FIFO word packer.
package fifo_pack_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    // Counters must be able to hold the value WORD_BYTES itself.
    function automatic int cnt_w(input int word_bytes);
        return $clog2(word_bytes + 1);
    endfunction

endpackage

// File: rtl/fifo_pack_lane.sv
// Byte-lane assembly register plus running XOR checksum for one output word.
module fifo_pack_lane
    import fifo_pack_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int IDX_W      = cnt_w(WORD_BYTES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [BYTE_W-1:0]            wr_byte,
    output logic [BYTE_W*WORD_BYTES-1:0] word,
    output logic [BYTE_W-1:0]            chk
);

    logic [BYTE_W*WORD_BYTES-1:0] word_q, word_d;
    logic [BYTE_W-1:0]            chk_q, chk_d;

    always_comb begin
        word_d = word_q;
        chk_d  = chk_q;
        if (clr) begin
            word_d = '0;
            chk_d  = '0;
        end else if (wr_en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (wr_idx == IDX_W'(i)) word_d[i*BYTE_W +: BYTE_W] = wr_byte;
            end
            chk_d = chk_q ^ wr_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            chk_q  <= '0;
        end else begin
            word_q <= word_d;
            chk_q  <= chk_d;
        end
    end

    assign word = word_q;
    assign chk  = chk_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from an 8-bit FIFO, packs WORD_BYTES of them into a word with an
// XOR checksum, and delivers it on a valid/ready stream.
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [7:0]              FIFO_DATA,
    input  logic                    FIFO_EMPTY,
    output logic                    FIFO_RD_EN,
    output logic [8*WORD_BYTES-1:0] OUT_DATA,
    output logic [7:0]              OUT_CHK,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [CNT_W-1:0]        WORD_CNT,
    output logic                    BUSY
);

    localparam int               IDX_W = cnt_w(WORD_BYTES);
    localparam logic [IDX_W-1:0] FULL  = IDX_W'(WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(WORD_BYTES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   iss_cnt_q, iss_cnt_d;
    logic [IDX_W-1:0]   rcv_cnt_q, rcv_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               rd_en;
    logic               accept;

    // RST term keeps the pop request low while reset is held.
    assign rd_en  = !RST && (state_q == FILL) && EN && !FIFO_EMPTY && (iss_cnt_q < FULL);
    assign accept = valid_q && OUT_READY;

    always_comb begin
        state_d    = state_q;
        iss_cnt_d  = iss_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        valid_d    = valid_q;
        word_cnt_d = word_cnt_q;
        rd_pend_d  = rd_en;

        if (rd_en)     iss_cnt_d = iss_cnt_q + IDX_W'(1);
        if (rd_pend_q) rcv_cnt_d = rcv_cnt_q + IDX_W'(1);

        if (rd_pend_q && rcv_cnt_q == LAST) begin
            state_d = HOLD;
            valid_d = 1'b1;
        end

        // No pop can be in flight here: iss_cnt is already saturated in HOLD.
        if (accept) begin
            state_d    = FILL;
            valid_d    = 1'b0;
            iss_cnt_d  = '0;
            rcv_cnt_d  = '0;
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= FILL;
            iss_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            valid_q    <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            iss_cnt_q  <= iss_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            rd_pend_q  <= rd_pend_d;
            valid_q    <= valid_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    fifo_pack_lane #(
        .WORD_BYTES (WORD_BYTES),
        .IDX_W      (IDX_W)
    ) u_lane (
        .clk     (CLK),
        .rst     (RST),
        .clr     (accept),
        .wr_en   (rd_pend_q),
        .wr_idx  (rcv_cnt_q),
        .wr_byte (FIFO_DATA),
        .word    (OUT_DATA),
        .chk     (OUT_CHK)
    );

    assign FIFO_RD_EN = rd_en;
    assign OUT_VALID  = valid_q;
    assign WORD_CNT   = word_cnt_q;
    assign BUSY       = (iss_cnt_q != '0) || valid_q;

endmodule
